// File: rtl/hsid_x_pkg.sv
// Shared types and constants for the HSI fetch sequencer and its address generator.
package hsid_x_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CHECK     = 3'd1,
    ST_CAP_START = 3'd2,
    ST_CAP_WAIT  = 3'd3,
    ST_LIB_START = 3'd4,
    ST_LIB_WAIT  = 3'd5,
    ST_DRAIN     = 3'd6,
    ST_FINISH    = 3'd7
  } hsid_x_fetch_state_t;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned BANDS_PER_WORD = 2;

  // Words needed to hold a pixel; the odd trailing band occupies half a word.
  function automatic int unsigned words_for_bands(input int unsigned bands);
    return (bands + BANDS_PER_WORD - 1) / BANDS_PER_WORD;
  endfunction

endpackage

// File: rtl/hsid_x_fetch_addr_gen.sv
// Library burst address generator: latches base/stride/last index on load and
// steps one pixel per advance, flagging the final library pixel.
module hsid_x_fetch_addr_gen #(
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned IDX_WIDTH  = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  advance,
  input  logic [WORD_WIDTH-1:0] base,
  input  logic [WORD_WIDTH-1:0] stride,
  input  logic [IDX_WIDTH-1:0]  last_idx,
  output logic [WORD_WIDTH-1:0] addr,
  output logic [IDX_WIDTH-1:0]  idx,
  output logic                  last
);

  logic [WORD_WIDTH-1:0] addr_q, addr_d;
  logic [WORD_WIDTH-1:0] stride_q, stride_d;
  logic [IDX_WIDTH-1:0]  idx_q, idx_d;
  logic [IDX_WIDTH-1:0]  last_idx_q, last_idx_d;
  logic                  last_q, last_d;

  always_comb begin
    addr_d     = addr_q;
    stride_d   = stride_q;
    idx_d      = idx_q;
    last_idx_d = last_idx_q;
    last_d     = last_q;
    if (load) begin
      addr_d     = base;
      stride_d   = stride;
      idx_d      = '0;
      last_idx_d = last_idx;
      last_d     = (last_idx == '0);
    end else if (advance) begin
      // Address wraps modulo 2^WORD_WIDTH by construction.
      addr_d = addr_q + stride_q;
      idx_d  = idx_q + IDX_WIDTH'(1);
      last_d = (idx_d == last_idx_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      stride_q   <= '0;
      idx_q      <= '0;
      last_idx_q <= '0;
      last_q     <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      stride_q   <= stride_d;
      idx_q      <= idx_d;
      last_idx_q <= last_idx_d;
      last_q     <= last_d;
    end
  end

  assign addr = addr_q;
  assign idx  = idx_q;
  assign last = last_q;

endmodule

// File: rtl/hsid_x_fetch_seq.sv
// OBI burst reader sequencer: one burst for the captured pixel, then one burst
// per library pixel, with config validation and clear-driven abort/drain.
module hsid_x_fetch_seq
  import hsid_x_pkg::*;
#(
  parameter int unsigned WORD_WIDTH            = 32,
  parameter int unsigned HSI_BANDS             = 254,
  parameter int unsigned HSI_LIBRARY_SIZE      = 4095,
  parameter int unsigned HSI_BANDS_ADDR        = $clog2(HSI_BANDS),
  parameter int unsigned HSI_LIBRARY_SIZE_ADDR = $clog2(HSI_LIBRARY_SIZE)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic                             clear,
  input  logic [HSI_BANDS_ADDR-1:0]        pixel_bands,
  input  logic [HSI_LIBRARY_SIZE_ADDR-1:0] library_size,
  input  logic [WORD_WIDTH-1:0]            captured_addr,
  input  logic [WORD_WIDTH-1:0]            library_addr,
  input  logic                             rd_ready,
  input  logic                             rd_done,
  output logic                             rd_start,
  output logic [WORD_WIDTH-1:0]            rd_addr,
  output logic [HSI_LIBRARY_SIZE_ADDR-1:0] rd_limit,
  output logic                             busy,
  output logic                             lib_phase,
  output logic [HSI_LIBRARY_SIZE_ADDR-1:0] pixel_idx,
  output logic                             done,
  output logic                             error
);

  localparam int unsigned WORDS_W = HSI_BANDS_ADDR + 1;

  hsid_x_fetch_state_t state_q, state_d;

  logic [HSI_BANDS_ADDR-1:0]        bands_q, bands_d;
  logic [HSI_LIBRARY_SIZE_ADDR-1:0] lib_size_q, lib_size_d;
  logic [WORD_WIDTH-1:0]            cap_addr_q, cap_addr_d;
  logic [WORD_WIDTH-1:0]            lib_addr_q, lib_addr_d;

  logic                             cfg_latch;
  logic                             gen_load;
  logic                             gen_advance;
  logic                             gen_last;
  logic [WORD_WIDTH-1:0]            gen_addr;
  logic [HSI_LIBRARY_SIZE_ADDR-1:0] gen_idx;

  logic [WORDS_W-1:0]               words;
  logic [WORD_WIDTH-1:0]            stride;
  logic [HSI_LIBRARY_SIZE_ADDR-1:0] last_idx;
  logic                             bands_too_big;
  logic                             lib_too_big;
  logic                             cfg_bad;

  // Upper-bound checks only exist when the port width can exceed the maximum.
  if (HSI_BANDS < (32'd1 << HSI_BANDS_ADDR) - 32'd1) begin : g_bands_chk
    assign bands_too_big = (bands_q > HSI_BANDS_ADDR'(HSI_BANDS));
  end else begin : g_bands_nochk
    assign bands_too_big = 1'b0;
  end

  if (HSI_LIBRARY_SIZE < (32'd1 << HSI_LIBRARY_SIZE_ADDR) - 32'd1) begin : g_lib_chk
    assign lib_too_big = (lib_size_q > HSI_LIBRARY_SIZE_ADDR'(HSI_LIBRARY_SIZE));
  end else begin : g_lib_nochk
    assign lib_too_big = 1'b0;
  end

  assign cfg_bad = (bands_q == '0) || bands_too_big ||
                   (lib_size_q == '0) || lib_too_big ||
                   (cap_addr_q[1:0] != 2'b00) || (lib_addr_q[1:0] != 2'b00);

  assign words    = WORDS_W'(words_for_bands(32'(bands_q)));
  assign stride   = WORD_WIDTH'(words) * WORD_WIDTH'(BYTES_PER_WORD);
  assign last_idx = lib_size_q - HSI_LIBRARY_SIZE_ADDR'(1);

  always_comb begin
    bands_d    = bands_q;
    lib_size_d = lib_size_q;
    cap_addr_d = cap_addr_q;
    lib_addr_d = lib_addr_q;
    if (cfg_latch) begin
      bands_d    = pixel_bands;
      lib_size_d = library_size;
      cap_addr_d = captured_addr;
      lib_addr_d = library_addr;
    end
  end

  always_comb begin
    state_d     = state_q;
    rd_start    = 1'b0;
    done        = 1'b0;
    error       = 1'b0;
    cfg_latch   = 1'b0;
    gen_load    = 1'b0;
    gen_advance = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !clear) begin
          cfg_latch = 1'b1;
          state_d   = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (clear) begin
          state_d = ST_IDLE;
        end else if (cfg_bad) begin
          error   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_CAP_START;
        end
      end
      ST_CAP_START: begin
        if (clear) begin
          state_d = ST_IDLE;
        end else if (rd_ready) begin
          rd_start = 1'b1;
          state_d  = ST_CAP_WAIT;
        end
      end
      // A burst is in flight: clear must wait for its rd_done unless it lands now.
      ST_CAP_WAIT: begin
        if (clear) begin
          state_d = rd_done ? ST_IDLE : ST_DRAIN;
        end else if (rd_done) begin
          gen_load = 1'b1;
          state_d  = ST_LIB_START;
        end
      end
      ST_LIB_START: begin
        if (clear) begin
          state_d = ST_IDLE;
        end else if (rd_ready) begin
          rd_start = 1'b1;
          state_d  = ST_LIB_WAIT;
        end
      end
      ST_LIB_WAIT: begin
        if (clear) begin
          state_d = rd_done ? ST_IDLE : ST_DRAIN;
        end else if (rd_done) begin
          if (gen_last) begin
            state_d = ST_FINISH;
          end else begin
            gen_advance = 1'b1;
            state_d     = ST_LIB_START;
          end
        end
      end
      ST_DRAIN: begin
        if (rd_done) begin
          state_d = ST_IDLE;
        end
      end
      ST_FINISH: begin
        if (!clear) begin
          done = 1'b1;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_addr = '0;
    case (state_q)
      ST_CAP_START: rd_addr = cap_addr_q;
      ST_LIB_START: rd_addr = gen_addr;
      default:      rd_addr = '0;
    endcase
  end

  assign busy      = (state_q != ST_IDLE);
  assign lib_phase = (state_q == ST_LIB_START) || (state_q == ST_LIB_WAIT) ||
                     (state_q == ST_FINISH);
  assign rd_limit  = HSI_LIBRARY_SIZE_ADDR'(words);
  assign pixel_idx = gen_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      bands_q    <= '0;
      lib_size_q <= '0;
      cap_addr_q <= '0;
      lib_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      bands_q    <= bands_d;
      lib_size_q <= lib_size_d;
      cap_addr_q <= cap_addr_d;
      lib_addr_q <= lib_addr_d;
    end
  end

  hsid_x_fetch_addr_gen #(
    .WORD_WIDTH (WORD_WIDTH),
    .IDX_WIDTH  (HSI_LIBRARY_SIZE_ADDR)
  ) u_addr_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (gen_load),
    .advance  (gen_advance),
    .base     (lib_addr_q),
    .stride   (stride),
    .last_idx (last_idx),
    .addr     (gen_addr),
    .idx      (gen_idx),
    .last     (gen_last)
  );

endmodule

// File: tb/tb_hsid_x_fetch_seq.sv
// Self-checking bench for hsid_x_fetch_seq with an emulated OBI burst reader.
module tb_hsid_x_fetch_seq;

  localparam int unsigned WW = 32;
  localparam int unsigned BA = 8;
  localparam int unsigned LA = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          clear = 1'b0;
  logic [BA-1:0] pixel_bands = '0;
  logic [LA-1:0] library_size = '0;
  logic [WW-1:0] captured_addr = '0;
  logic [WW-1:0] library_addr = '0;
  logic          rd_ready;
  logic          rd_done;
  logic          rd_start;
  logic [WW-1:0] rd_addr;
  logic [LA-1:0] rd_limit;
  logic          busy;
  logic          lib_phase;
  logic [LA-1:0] pixel_idx;
  logic          done;
  logic          error;

  always #5 clk = ~clk;

  hsid_x_fetch_seq #(
    .WORD_WIDTH       (32),
    .HSI_BANDS        (254),
    .HSI_LIBRARY_SIZE (4095)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .clear         (clear),
    .pixel_bands   (pixel_bands),
    .library_size  (library_size),
    .captured_addr (captured_addr),
    .library_addr  (library_addr),
    .rd_ready      (rd_ready),
    .rd_done       (rd_done),
    .rd_start      (rd_start),
    .rd_addr       (rd_addr),
    .rd_limit      (rd_limit),
    .busy          (busy),
    .lib_phase     (lib_phase),
    .pixel_idx     (pixel_idx),
    .done          (done),
    .error         (error)
  );

  typedef struct {
    logic [WW-1:0] addr;
    logic [LA-1:0] limit;
    logic [LA-1:0] idx;
    logic          phase;
    int            cyc;
    int            done_cyc;
  } burst_t;

  burst_t bursts[$];
  int cyc = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int done_cyc = -1;
  int err_cyc = -1;
  int start_cyc = -1;
  int viol = 0;
  int lat_cfg = 3;
  int stall_cfg = 0;
  int rd_cnt = 0;
  int stall_cnt = 0;
  int n_checks = 0;
  int n_fail = 0;

  // Reader emulator + monitor: observe at negedge, drive reader outputs after posedge.
  initial begin
    burst_t b;
    rd_ready = 1'b1;
    rd_done  = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n) begin
        if (start && !busy) start_cyc = cyc;
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (error) begin err_cnt++; err_cyc = cyc; end
        if (rd_done && bursts.size() > 0) bursts[bursts.size()-1].done_cyc = cyc;
        if (rd_start) begin
          if (!rd_ready || rd_cnt != 0) viol++;
          b.addr = rd_addr; b.limit = rd_limit; b.idx = pixel_idx;
          b.phase = lib_phase; b.cyc = cyc; b.done_cyc = -1;
          bursts.push_back(b);
          rd_cnt = (lat_cfg == 0) ? int'($urandom_range(1, 5)) : lat_cfg;
        end
      end
      @(posedge clk); #1;
      rd_done = 1'b0;
      if (rd_cnt > 0) begin
        rd_cnt--;
        if (rd_cnt == 0) begin rd_done = 1'b1; stall_cnt = stall_cfg + 1; end
      end else if (stall_cnt > 0) begin
        stall_cnt--;
      end
      rd_ready = (rd_cnt == 0) && (stall_cnt == 0);
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic run_seq(input string name, input int bands, input int lsz,
                         input logic [WW-1:0] cap, input logic [WW-1:0] laddr,
                         input bit poke);
    int n0, d0, e0, words, last;
    bit valid, finished;
    logic [WW-1:0] stride, exp_addr;
    burst_t b;
    valid = (bands >= 1) && (bands <= 254) && (lsz >= 1) && (lsz <= 4095) &&
            (cap[1:0] == 2'b00) && (laddr[1:0] == 2'b00);
    words  = (bands + 1) / 2;
    stride = WW'(words * 4);
    n0 = bursts.size(); d0 = done_cnt; e0 = err_cnt;
    @(posedge clk); #1;
    pixel_bands = BA'(bands); library_size = LA'(lsz);
    captured_addr = cap; library_addr = laddr; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    pixel_bands = BA'($urandom); library_size = LA'($urandom);
    captured_addr = $urandom; library_addr = $urandom;
    finished = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (done_cnt != d0 || err_cnt != e0) begin finished = 1'b1; break; end
      start = poke && (i == 3);
      @(posedge clk); #1;
    end
    start = 1'b0;
    n_checks++;
    if (!finished) begin
      n_fail++; $display("FAIL %s timeout: finished=%0d required 1", name, finished);
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL %s busy_after: got %b want 0", name, busy); end
    if (valid) begin
      n_checks++;
      if (done_cnt !== d0 + 1) begin n_fail++; $display("FAIL %s done_pulses: got %0d want 1", name, done_cnt - d0); end
      n_checks++;
      if (err_cnt !== e0) begin n_fail++; $display("FAIL %s error_pulses: got %0d want 0", name, err_cnt - e0); end
      n_checks++;
      if (bursts.size() !== n0 + 1 + lsz) begin
        n_fail++; $display("FAIL %s burst_count: got %0d want %0d", name, bursts.size() - n0, 1 + lsz);
      end else begin
        for (int k = 0; k <= lsz; k++) begin
          b = bursts[n0 + k];
          exp_addr = (k == 0) ? cap : laddr + stride * WW'(k - 1);
          n_checks++;
          if (b.addr !== exp_addr) begin n_fail++; $display("FAIL %s addr[%0d]: got %h want %h", name, k, b.addr, exp_addr); end
          n_checks++;
          if (b.limit !== LA'(words)) begin n_fail++; $display("FAIL %s limit[%0d]: got %0d want %0d", name, k, b.limit, words); end
          n_checks++;
          if (b.phase !== (k != 0)) begin n_fail++; $display("FAIL %s phase[%0d]: got %b want %b", name, k, b.phase, k != 0); end
          if (k > 0) begin
            n_checks++;
            if (b.idx !== LA'(k - 1)) begin n_fail++; $display("FAIL %s pixel_idx[%0d]: got %0d want %0d", name, k, b.idx, k - 1); end
            n_checks++;
            if (b.cyc !== bursts[n0 + k - 1].done_cyc + 1 + stall_cfg) begin
              n_fail++; $display("FAIL %s start_gap[%0d]: got %0d want %0d", name, k,
                                 b.cyc - bursts[n0 + k - 1].done_cyc, 1 + stall_cfg);
            end
          end else if (stall_cfg == 0) begin
            n_checks++;
            if (b.cyc !== start_cyc + 2) begin n_fail++; $display("FAIL %s first_latency: got %0d want 2", name, b.cyc - start_cyc); end
          end
        end
        last = bursts[n0 + lsz].done_cyc;
        n_checks++;
        if (done_cyc !== last + 1) begin n_fail++; $display("FAIL %s done_timing: got %0d want %0d", name, done_cyc, last + 1); end
      end
    end else begin
      n_checks++;
      if (err_cnt !== e0 + 1) begin n_fail++; $display("FAIL %s error_pulses: got %0d want 1", name, err_cnt - e0); end
      n_checks++;
      if (done_cnt !== d0) begin n_fail++; $display("FAIL %s done_pulses: got %0d want 0", name, done_cnt - d0); end
      n_checks++;
      if (err_cyc !== start_cyc + 1) begin n_fail++; $display("FAIL %s error_latency: got %0d want 1", name, err_cyc - start_cyc); end
      n_checks++;
      if (bursts.size() !== n0) begin n_fail++; $display("FAIL %s no_bursts: got %0d want 0", name, bursts.size() - n0); end
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({rd_start, busy, done, error, lib_phase} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b want 00000", {rd_start, busy, done, error, lib_phase});
    end
    n_checks++;
    if (rd_addr !== '0) begin n_fail++; $display("FAIL reset_rd_addr: got %h want 0", rd_addr); end
    n_checks++;
    if ({rd_limit, pixel_idx} !== '0) begin n_fail++; $display("FAIL reset_limit_idx: got %h want 0", {rd_limit, pixel_idx}); end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    lat_cfg = 3; stall_cfg = 0;
    run_seq("basic", 4, 3, 32'h100, 32'h200, 1'b0);
    run_seq("odd_bands", 5, 3, 32'h100, 32'h200, 1'b0);
    run_seq("addr_wrap", 4, 3, 32'h10, 32'hFFFF_FFF8, 1'b0);
    run_seq("max_bands", 254, 2, 32'h0, 32'h1000, 1'b0);
    run_seq("min_cfg", 1, 1, 32'h4, 32'h8, 1'b0);
  endtask

  task automatic test_bad_config;
    lat_cfg = 3; stall_cfg = 0;
    run_seq("bad_bands0", 0, 3, 32'h100, 32'h200, 1'b0);
    run_seq("bad_lib0", 4, 0, 32'h100, 32'h200, 1'b0);
    run_seq("bad_cap_align", 4, 3, 32'h102, 32'h200, 1'b0);
    run_seq("bad_lib_align", 4, 3, 32'h100, 32'h201, 1'b0);
    run_seq("bad_bands255", 255, 3, 32'h100, 32'h200, 1'b0);
  endtask

  task automatic test_clear_drain;
    int n0, d0, e0;
    bit ok;
    lat_cfg = 8; stall_cfg = 0;
    n0 = bursts.size(); d0 = done_cnt; e0 = err_cnt;
    @(posedge clk); #1;
    pixel_bands = 8'd4; library_size = 12'd3;
    captured_addr = 32'h100; library_addr = 32'h200; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bursts.size() >= n0 + 3) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL drain_reach_pixel1: got %0d bursts want 3", bursts.size() - n0); end
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL drain_busy: got %b want 1", busy); end
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bursts.size() >= n0 + 3 && bursts[n0 + 2].done_cyc >= 0) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_checks++;
    if (!ok || busy !== 1'b0) begin n_fail++; $display("FAIL drain_idle: got ok=%0d busy=%b want ok=1 busy=0", ok, busy); end
    n_checks++;
    if (bursts.size() !== n0 + 3) begin n_fail++; $display("FAIL drain_no_start: got %0d bursts want 3", bursts.size() - n0); end
    n_checks++;
    if (done_cnt !== d0 || err_cnt !== e0) begin
      n_fail++; $display("FAIL drain_no_pulse: got done=%0d err=%0d want 0 0", done_cnt - d0, err_cnt - e0);
    end
    lat_cfg = 3;
    run_seq("restart_after_drain", 4, 3, 32'h100, 32'h200, 1'b0);
  endtask

  task automatic test_clear_with_done;
    int n0;
    bit ok;
    lat_cfg = 2; stall_cfg = 0;
    n0 = bursts.size();
    @(posedge clk); #1;
    pixel_bands = 8'd6; library_size = 12'd2;
    captured_addr = 32'h40; library_addr = 32'h80; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (bursts.size() >= n0 + 1) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    @(negedge clk);
    n_checks++;
    if (!ok || busy !== 1'b0) begin n_fail++; $display("FAIL clear_with_done_idle: got ok=%0d busy=%b want ok=1 busy=0", ok, busy); end
    n_checks++;
    if (!ok || bursts[n0].done_cyc !== bursts[n0].cyc + 2) begin
      n_fail++; $display("FAIL clear_with_done_overlap: got ok=%0d want ok=1 and rd_done in clear cycle", ok);
    end
    repeat (4) @(negedge clk);
    n_checks++;
    if (bursts.size() !== n0 + 1) begin n_fail++; $display("FAIL clear_with_done_no_start: got %0d bursts want 1", bursts.size() - n0); end
    lat_cfg = 3;
    run_seq("restart_after_clear", 3, 2, 32'h40, 32'h80, 1'b0);
  endtask

  task automatic test_ready_stall;
    lat_cfg = 3; stall_cfg = 5;
    run_seq("ready_stall", 4, 3, 32'h100, 32'h200, 1'b0);
    stall_cfg = 0;
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic test_start_clear_idle;
    int n0, d0, e0;
    n0 = bursts.size(); d0 = done_cnt; e0 = err_cnt;
    @(posedge clk); #1;
    pixel_bands = 8'd4; library_size = 12'd3;
    captured_addr = 32'h100; library_addr = 32'h200;
    start = 1'b1; clear = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; clear = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL start_clear_idle_busy: got %b want 0", busy); end
    repeat (4) @(negedge clk);
    n_checks++;
    if (bursts.size() !== n0 || done_cnt !== d0 || err_cnt !== e0) begin
      n_fail++; $display("FAIL start_clear_idle_quiet: got bursts=%0d done=%0d err=%0d want 0 0 0",
                         bursts.size() - n0, done_cnt - d0, err_cnt - e0);
    end
  endtask

  task automatic test_start_while_busy;
    lat_cfg = 3; stall_cfg = 0;
    run_seq("start_while_busy", 4, 3, 32'h300, 32'h400, 1'b1);
  endtask

  task automatic test_back_to_back;
    lat_cfg = 1; stall_cfg = 0;
    run_seq("b2b_a", 2, 2, 32'h0, 32'h20, 1'b0);
    run_seq("b2b_b", 7, 3, 32'h100, 32'hFFFF_FFF0, 1'b0);
  endtask

  task automatic test_random;
    int bands, lsz;
    logic [WW-1:0] cap, laddr;
    lat_cfg = 0; stall_cfg = 0;
    for (int it = 0; it < 10; it++) begin
      bands = int'($urandom_range(1, 254));
      lsz   = int'($urandom_range(1, 5));
      cap   = $urandom & 32'hFFFF_FFFC;
      laddr = $urandom & 32'hFFFF_FFFC;
      case ($urandom_range(0, 6))
        0: bands = 0;
        1: cap[1:0] = 2'($urandom_range(1, 3));
        2: bands = 255;
        3: laddr[1:0] = 2'($urandom_range(1, 3));
        default: ;
      endcase
      run_seq("random", bands, lsz, cap, laddr, 1'b0);
    end
    lat_cfg = 3;
  endtask

  task automatic test_protocol;
    n_checks++;
    if (viol !== 0) begin n_fail++; $display("FAIL protocol: got %0d rd_start violations want 0", viol); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_config();
    test_clear_drain();
    test_clear_with_done();
    test_ready_stall();
    test_start_clear_idle();
    test_start_while_busy();
    test_back_to_back();
    test_random();
    test_protocol();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
